sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Parametrised single-clock FIFO for buffering capture-pipeline words (pixels, line descriptors) between producer and consumer stages.
- Supersedes the dual-clock-edge stack-like buffer with true first-in-first-out ordering, a valid/ready-style handshake and full/empty/level status.
- Adds first-word-fall-through (FWFT) mode, sticky overflow/underflow flags and a last-word indication.

Parameters:
DATA_WIDTH, 32, word width in bits.
FIFO_DEPTH, 8, number of entries; power of two, >= 2.
FWFT_MODE, 0, 0 = registered read (1-cycle latency); 1 = head word visible on pop_data while not empty.
ALMOST_FULL_LEVEL, FIFO_DEPTH-1, almost_full asserted when count >= this value.
ALMOST_EMPTY_LEVEL, 1, almost_empty asserted when count <= this value.
ADDR_WIDTH (localparam), clog2(FIFO_DEPTH), pointer index width.

Ports:
clock  in  1  single clock; all logic on rising edge.
reset  in  1  synchronous, active-high.
enable  in  1  when low, push/pop ignored; state held.
clear  in  1  synchronous flush of pointers, count and flags.
push  in  1  write request.
push_data  in  DATA_WIDTH  write word.
full  out  1  count == FIFO_DEPTH.
almost_full  out  1  count >= ALMOST_FULL_LEVEL.
pop  in  1  read request.
pop_data  out  DATA_WIDTH  read word.
pop_valid  out  1  pop_data holds a valid word.
empty  out  1  count == 0.
almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
count  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
popped_last  out  1  one-cycle pulse: an accepted pop left the FIFO empty.
overflow  out  1  sticky: push rejected because full.
underflow  out  1  sticky: pop rejected because empty.

Behaviour:
- Reset (sync, highest priority): wr_ptr = rd_ptr = 0, count = 0, pop_data = 0, pop_valid = 0 (FWFT: follows empty, so 0), popped_last = 0, overflow = underflow = 0; empty = 1, full = 0, almost_empty = 1, almost_full = 0 (unless ALMOST_FULL_LEVEL = 0). Memory contents not reset.
- Priority: reset > clear > enable-gated push/pop.
- clear: same register effect as reset; a push/pop in the same cycle is discarded.
- Accept rules (enable = 1):
  - push_acc = push && (!full || pop_acc).
  - pop_acc = pop && !empty. A pop on an empty FIFO is never satisfied by a same-cycle push.
- Pointers: ADDR_WIDTH+1 bits. Write at wr_ptr[ADDR_WIDTH-1:0]; increment on push_acc and wrap naturally.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. All flags are registered, derived from next-count; no combinational flag paths from push/pop.
- Mode 0: on pop_acc, pop_data <= mem[rd_idx] and pop_valid <= 1 next cycle; otherwise pop_valid <= 0 and pop_data holds its last value.
- Mode 1: pop_data = mem[rd_idx] and pop_valid = !empty. A pop consumes the displayed word, and the next word appears the cycle after. A word pushed into an empty FIFO is visible the cycle after the push.
- popped_last <= pop_acc && count == 1 && !push_acc.
- overflow <= overflow | (push && full && !pop_acc). underflow <= underflow | (pop && empty). Both cleared only by reset or clear.
- enable = 0: no accepts, no sticky updates; outputs hold, except in mode 0, where pop_valid drops to 0.

Decomposition:
- Shared include/package "fifo_defs": clog2 function, FWFT_MODE constants (FIFO_MODE_STD = 0, FIFO_MODE_FWFT = 1).
- Sub-module fifo_ram: simple dual-port array, sync write, async read index. Width and depth parameters only; no reset.
- Control (pointers, count, flags) stays in sync_fifo.

Test Plan:
1. DEPTH = 8, mode 0: push 0x11..0x88 (8 words) -> full = 1, count = 8, almost_full set at count 7. A 9th push of 0x99 -> rejected, overflow = 1, count stays 8.
2. Pop 8 times from test 1 -> pop_data 0x11..0x88 in order, each 1 cycle after the pop. popped_last pulses on the 8th; empty = 1. A further pop -> underflow = 1, pop_valid = 0.
3. Full FIFO, push 0xAA and pop together -> count stays 8, full stays 1, no overflow. 0xAA is read out 8th after the remaining words.
4. Wrap-around: 12 interleaved push/pop cycles at count 3 -> ordering preserved across pointer wrap; count constant at 3.
5. Mode 1: push 0x5A into empty FIFO -> next cycle pop_valid = 1, pop_data = 0x5A without a pop. A pop then gives empty = 1 and a popped_last pulse.
6. count = 5 with overflow set, assert clear with push = 1 -> next cycle count = 0, empty = 1, overflow = 0, push discarded. A mid-operation reset gives identical results.

Source files
------------

// File: rtl/fifo_defs_pkg.sv
// Shared definitions for the sync_fifo codebase slice.
//   clog2()          : ceiling log2, used to size pointers and indices
//   FIFO_MODE_STD    : registered read, data valid one cycle after a pop
//   FIFO_MODE_FWFT   : first-word-fall-through, head word always on pop_data
package fifo_defs_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    // Smallest r such that 2**r >= value (returns 0 for value <= 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array for sync_fifo.
//   clock     : write clock (rising edge)
//   wr_en     : write strobe
//   wr_addr   : write index
//   wr_data   : write word
//   rd_addr   : read index
//   rd_data_c : word at rd_addr, combinational (no read latency)
// Contents are not reset.
module fifo_ram
    import fifo_defs_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned DEPTH      = 8,
    localparam int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data_c
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read port.
    assign rd_data_c = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with valid/ready-style push/pop, status flags, sticky
// overflow/underflow and an optional first-word-fall-through read path.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   enable           : gates push/pop acceptance and sticky updates
//   clear            : synchronous flush (same register effect as reset)
//   push, push_data  : write request and word
//   pop              : read request
//   pop_data         : read word (registered in STD mode, head word in FWFT)
//   pop_valid        : pop_data holds a valid word
//   full/almost_full, empty/almost_empty, count : occupancy status
//   popped_last      : pulse, an accepted pop left the FIFO empty
//   overflow/underflow : sticky rejected-push / rejected-pop flags
module sync_fifo
    import fifo_defs_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH         = 32,
    parameter  int unsigned FIFO_DEPTH         = 8,
    parameter  int unsigned FWFT_MODE          = FIFO_MODE_STD,
    parameter  int unsigned ALMOST_FULL_LEVEL  = FIFO_DEPTH - 1,
    parameter  int unsigned ALMOST_EMPTY_LEVEL = 1,
    localparam int unsigned ADDR_WIDTH         = clog2(FIFO_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  popped_last,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [CNT_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  empty_q, empty_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  popped_last_q, popped_last_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  pop_valid_q, pop_valid_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;

    logic                  push_acc_c;
    logic                  pop_acc_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_ram (
        .clock     (clock),
        .wr_en     (push_acc_c),
        .wr_addr   (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data   (push_data),
        .rd_addr   (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data_c (rd_data_c)
    );

    // Accept logic: a full FIFO can take a push only if a pop frees a slot
    // in the same cycle; an empty FIFO never pops a same-cycle push.
    always_comb begin
        pop_acc_c  = enable && !clear && pop && !empty_q;
        push_acc_c = enable && !clear && push && (!full_q || pop_acc_c);
    end

    // Next-state for pointers, count, read register and flags.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        pop_data_d    = pop_data_q;
        pop_valid_d   = 1'b0;
        popped_last_d = 1'b0;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pop_data_d  = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc_c) begin
                wr_ptr_d = wr_ptr_q + CNT_WIDTH'(1);
            end
            if (pop_acc_c) begin
                rd_ptr_d    = rd_ptr_q + CNT_WIDTH'(1);
                pop_data_d  = rd_data_c;
                pop_valid_d = 1'b1;
            end
            case ({push_acc_c, pop_acc_c})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
            popped_last_d = pop_acc_c && (count_q == CNT_WIDTH'(1)) && !push_acc_c;
            overflow_d    = overflow_q  | (enable && push && full_q && !pop_acc_c);
            underflow_d   = underflow_q | (enable && pop && empty_q);
        end

        full_d         = (count_d == CNT_WIDTH'(FIFO_DEPTH));
        almost_full_d  = (count_d >= CNT_WIDTH'(ALMOST_FULL_LEVEL));
        empty_d        = (count_d == '0);
        almost_empty_d = (count_d <= CNT_WIDTH'(ALMOST_EMPTY_LEVEL));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            almost_full_q  <= (ALMOST_FULL_LEVEL == 0);
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            popped_last_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
            pop_valid_q    <= 1'b0;
            pop_data_q     <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
            almost_empty_q <= almost_empty_d;
            popped_last_q  <= popped_last_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
            pop_valid_q    <= pop_valid_d;
            pop_data_q     <= pop_data_d;
        end
    end

    // FWFT shows the head slot directly; it is forced to zero while empty so
    // that unreset storage never leaks onto pop_data.
    assign pop_valid    = (FWFT_MODE == FIFO_MODE_FWFT) ? !empty_q : pop_valid_q;
    assign pop_data     = (FWFT_MODE == FIFO_MODE_FWFT) ? (empty_q ? '0 : rd_data_c)
                                                        : pop_data_q;
    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign popped_last  = popped_last_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: one STD-mode and one FWFT-mode instance
// share the same stimulus and are checked against a queue-based model.
module tb_sync_fifo;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;

    logic          clock = 1'b0;
    logic          reset, enable, clear, push, pop;
    logic [DW-1:0] push_data;

    logic          full0, af0, pv0, empty0, ae0, pl0, ov0, un0;
    logic [DW-1:0] pd0;
    logic [3:0]    cnt0;
    logic          full1, af1, pv1, empty1, ae1, pl1, ov1, un1;
    logic [DW-1:0] pd1;
    logic [3:0]    cnt1;
    logic [10:0]   st0, st1;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_pd0;
    logic          m_pv0, m_pl, m_ov, m_un;

    always #5 clock = ~clock;

    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT_MODE(0)) dut0 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .push(push), .push_data(push_data), .full(full0), .almost_full(af0),
        .pop(pop), .pop_data(pd0), .pop_valid(pv0), .empty(empty0),
        .almost_empty(ae0), .count(cnt0), .popped_last(pl0),
        .overflow(ov0), .underflow(un0)
    );

    sync_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .FWFT_MODE(1)) dut1 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .push(push), .push_data(push_data), .full(full1), .almost_full(af1),
        .pop(pop), .pop_data(pd1), .pop_valid(pv1), .empty(empty1),
        .almost_empty(ae1), .count(cnt1), .popped_last(pl1),
        .overflow(ov1), .underflow(un1)
    );

    assign st0 = {full0, af0, empty0, ae0, ov0, un0, pl0, cnt0};
    assign st1 = {full1, af1, empty1, ae1, ov1, un1, pl1, cnt1};

    // Expected status vector {full, af, empty, ae, ov, un, pl, count}.
    function automatic logic [10:0] m_status();
        int n;
        n = mq.size();
        return {n == int'(DEPTH), n >= int'(DEPTH) - 1, n == 0, n <= 1,
                m_ov, m_un, m_pl, 4'(n)};
    endfunction

    function automatic logic [DW-1:0] m_head();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    // Drive one cycle and advance the model by the FIFO's rules.
    task automatic step(input logic rst, input logic clr, input logic en,
                        input logic ps, input logic [DW-1:0] d, input logic pp);
        int   n;
        logic pa, wa;
        reset = rst; clear = clr; enable = en; push = ps; push_data = d; pop = pp;
        @(posedge clock);
        n = mq.size();
        if (rst || clr) begin
            mq.delete();
            m_pd0 = '0; m_pv0 = 1'b0; m_pl = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else if (en) begin
            pa    = pp && (n > 0);
            wa    = ps && ((n < int'(DEPTH)) || pa);
            m_ov  = m_ov | (ps && (n == int'(DEPTH)) && !pa);
            m_un  = m_un | (pp && (n == 0));
            m_pl  = pa && (n == 1) && !wa;
            m_pv0 = pa;
            if (pa) m_pd0 = mq.pop_front();
            if (wa) mq.push_back(d);
        end else begin
            m_pv0 = 1'b0;
            m_pl  = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 1, 0, '0, 0);
        tests++;
        if (st0 !== 11'b0011_000_0000) begin
            fails++; $display("FAIL reset_status0 got %b exp %b", st0, 11'b0011_000_0000);
        end
        tests++;
        if (st1 !== 11'b0011_000_0000) begin
            fails++; $display("FAIL reset_status1 got %b exp %b", st1, 11'b0011_000_0000);
        end
        tests++;
        if ({pv0, pd0, pv1, pd1} !== '0) begin
            fails++; $display("FAIL reset_pop got pv0=%b pd0=%h pv1=%b pd1=%h exp zeros",
                              pv0, pd0, pv1, pd1);
        end
    endtask

    task automatic test_fill_overflow();
        step(1, 0, 1, 0, '0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 1, DW'(17 * i), 0);
            tests++;
            if (st0 !== m_status() || st1 !== m_status()) begin
                fails++; $display("FAIL fill_status[%0d] got %b/%b exp %b", i, st0, st1, m_status());
            end
            tests++;
            if (cnt0 !== 4'(i) || af0 !== (i >= 7) || full0 !== (i == 8)) begin
                fails++; $display("FAIL fill_flags[%0d] got cnt=%0d af=%b full=%b exp cnt=%0d af=%b full=%b",
                                  i, cnt0, af0, full0, i, i >= 7, i == 8);
            end
        end
        step(0, 0, 1, 1, 32'h99, 0);
        tests++;
        if (ov0 !== 1'b1 || cnt0 !== 4'd8 || full0 !== 1'b1 || ov1 !== 1'b1) begin
            fails++; $display("FAIL overflow got ov=%b/%b cnt=%0d full=%b exp ov=1 cnt=8 full=1",
                              ov0, ov1, cnt0, full0);
        end
    endtask

    task automatic test_drain_underflow();
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 0, '0, 1);
            tests++;
            if (pd0 !== DW'(17 * i) || pv0 !== 1'b1) begin
                fails++; $display("FAIL drain_data[%0d] got %h v=%b exp %h v=1", i, pd0, pv0, DW'(17 * i));
            end
            tests++;
            if (pl0 !== (i == 8) || empty0 !== (i == 8) || st1 !== m_status()) begin
                fails++; $display("FAIL drain_last[%0d] got pl=%b empty=%b st1=%b exp pl=%b empty=%b st1=%b",
                                  i, pl0, empty0, st1, i == 8, i == 8, m_status());
            end
        end
        step(0, 0, 1, 0, '0, 1);
        tests++;
        if (un0 !== 1'b1 || pv0 !== 1'b0 || un1 !== 1'b1 || pv1 !== 1'b0 || pl0 !== 1'b0) begin
            fails++; $display("FAIL underflow got un=%b/%b pv=%b/%b pl=%b exp un=1 pv=0 pl=0",
                              un0, un1, pv0, pv1, pl0);
        end
    endtask

    task automatic test_full_push_pop();
        logic [DW-1:0] exp;
        step(1, 0, 1, 0, '0, 0);
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 1, DW'(17 * i), 0);
        step(0, 0, 1, 1, 32'hAA, 1);
        tests++;
        if (cnt0 !== 4'd8 || full0 !== 1'b1 || ov0 !== 1'b0 || pd0 !== 32'h11) begin
            fails++; $display("FAIL full_pushpop got cnt=%0d full=%b ov=%b pd=%h exp cnt=8 full=1 ov=0 pd=11",
                              cnt0, full0, ov0, pd0);
        end
        for (int k = 0; k < 8; k++) begin
            exp = (k < 7) ? DW'(17 * (k + 2)) : 32'hAA;
            step(0, 0, 1, 0, '0, 1);
            tests++;
            if (pd0 !== exp || pv0 !== 1'b1) begin
                fails++; $display("FAIL full_order[%0d] got %h exp %h", k, pd0, exp);
            end
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 1, 0, '0, 0);
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 1, DW'(i), 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1, DW'(4 + i), 1);
            tests++;
            if (pd0 !== DW'(i + 1) || cnt0 !== 4'd3 || cnt1 !== 4'd3) begin
                fails++; $display("FAIL wrap[%0d] got pd=%h cnt=%0d/%0d exp pd=%h cnt=3",
                                  i, pd0, cnt0, cnt1, DW'(i + 1));
            end
            tests++;
            if (pd1 !== DW'(i + 2) || pv1 !== 1'b1) begin
                fails++; $display("FAIL wrap_fwft[%0d] got %h exp %h", i, pd1, DW'(i + 2));
            end
        end
        for (int i = 13; i <= 15; i++) begin
            step(0, 0, 1, 0, '0, 1);
            tests++;
            if (pd0 !== DW'(i)) begin
                fails++; $display("FAIL wrap_drain[%0d] got %h exp %h", i, pd0, DW'(i));
            end
        end
    endtask

    task automatic test_fwft();
        step(1, 0, 1, 0, '0, 0);
        step(0, 0, 1, 1, 32'h5A, 0);
        tests++;
        if (pv1 !== 1'b1 || pd1 !== 32'h5A || pv0 !== 1'b0) begin
            fails++; $display("FAIL fwft_show got pv1=%b pd1=%h pv0=%b exp pv1=1 pd1=5a pv0=0", pv1, pd1, pv0);
        end
        step(0, 0, 1, 0, '0, 0);
        tests++;
        if (pv1 !== 1'b1 || pd1 !== 32'h5A) begin
            fails++; $display("FAIL fwft_hold got pv1=%b pd1=%h exp 1/5a", pv1, pd1);
        end
        step(0, 0, 1, 0, '0, 1);
        tests++;
        if (empty1 !== 1'b1 || pl1 !== 1'b1 || pv1 !== 1'b0) begin
            fails++; $display("FAIL fwft_pop got empty=%b pl=%b pv=%b exp 1/1/0", empty1, pl1, pv1);
        end
        step(0, 0, 1, 1, 32'h01, 0);
        step(0, 0, 1, 1, 32'h02, 0);
        step(0, 0, 1, 0, '0, 1);
        tests++;
        if (pd1 !== 32'h02 || pv1 !== 1'b1 || pl1 !== 1'b0) begin
            fails++; $display("FAIL fwft_next got pd=%h pv=%b pl=%b exp 02/1/0", pd1, pv1, pl1);
        end
    endtask

    task automatic test_clear_reset();
        for (int v = 0; v < 2; v++) begin
            step(1, 0, 1, 0, '0, 0);
            for (int i = 1; i <= 9; i++) step(0, 0, 1, 1, DW'(i), 0);
            for (int i = 0; i < 3; i++) step(0, 0, 1, 0, '0, 1);
            tests++;
            if (cnt0 !== 4'd5 || ov0 !== 1'b1) begin
                fails++; $display("FAIL flush_setup[%0d] got cnt=%0d ov=%b exp 5/1", v, cnt0, ov0);
            end
            step(v == 1, v == 0, 1, 1, 32'hDEAD, 0);
            tests++;
            if (cnt0 !== 4'd0 || empty0 !== 1'b1 || ov0 !== 1'b0 || st1 !== 11'b0011_000_0000) begin
                fails++; $display("FAIL flush[%0d] got cnt=%0d empty=%b ov=%b st1=%b exp 0/1/0 st1=00110000000",
                                  v, cnt0, empty0, ov0, st1);
            end
            step(0, 0, 1, 0, '0, 0);
            tests++;
            if (cnt0 !== 4'd0 || pv1 !== 1'b0 || pd0 !== '0) begin
                fails++; $display("FAIL flush_discard[%0d] got cnt=%0d pv1=%b pd0=%h exp 0/0/0",
                                  v, cnt0, pv1, pd0);
            end
        end
    endtask

    task automatic test_random();
        int   ppush;
        logic rst, clr, en, ps, pp;
        step(1, 0, 1, 0, '0, 0);
        for (int i = 0; i < 600; i++) begin
            ppush = ((i / 60) % 2 == 0) ? 70 : 30;
            rst   = ($urandom_range(0, 199) == 0);
            clr   = ($urandom_range(0, 149) == 0);
            en    = ($urandom_range(0, 9) != 0);
            ps    = ($urandom_range(0, 99) < ppush);
            pp    = ($urandom_range(0, 99) < (100 - ppush));
            step(rst, clr, en, ps, DW'($urandom), pp);
            tests++;
            if (st0 !== m_status()) begin
                fails++; $display("FAIL rand_status0[%0d] got %b exp %b", i, st0, m_status());
            end
            tests++;
            if (st1 !== m_status()) begin
                fails++; $display("FAIL rand_status1[%0d] got %b exp %b", i, st1, m_status());
            end
            tests++;
            if (pv0 !== m_pv0 || pd0 !== m_pd0) begin
                fails++; $display("FAIL rand_std[%0d] got v=%b d=%h exp v=%b d=%h", i, pv0, pd0, m_pv0, m_pd0);
            end
            tests++;
            if (pv1 !== (mq.size() > 0) || pd1 !== m_head()) begin
                fails++; $display("FAIL rand_fwft[%0d] got v=%b d=%h exp v=%b d=%h",
                                  i, pv1, pd1, mq.size() > 0, m_head());
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        push = 1'b0; pop = 1'b0; push_data = '0;
        m_pd0 = '0; m_pv0 = 1'b0; m_pl = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_full_push_pop();
        test_wrap();
        test_fwft();
        test_clear_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
